// File: rtl/sim_dram_mux.sv
// N-port front end sharing one single-port DRAM model: round-robin request arbitration with a
// request lock, plus per-class order FIFOs of port indices that route in-order responses home.

module sim_dram_mux_ofifo #(
  parameter int Depth = 8,
  parameter int W     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);
  localparam int PtrW = $clog2(Depth);

  logic [W-1:0]    r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (PtrW+1)'(Depth));
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;
  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module sim_dram_mux #(
  parameter int NumPorts         = 4,
  parameter int DataWidth        = 512,
  parameter int AddrWidth        = 64,
  parameter int MaxRdOutstanding = 8,
  parameter int MaxWrOutstanding = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               req_valid_i,
  output logic [NumPorts-1:0]               req_ready_o,
  input  logic [NumPorts-1:0]               we_i,
  input  logic [NumPorts*AddrWidth-1:0]     addr_i,
  input  logic [NumPorts*DataWidth-1:0]     wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0]   wstrb_i,
  output logic [NumPorts-1:0]               rsp_valid_o,
  input  logic [NumPorts-1:0]               rsp_ready_i,
  output logic [DataWidth-1:0]              rdata_o,
  output logic [NumPorts-1:0]               b_valid_o,
  input  logic [NumPorts-1:0]               b_ready_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic                              mem_we_o,
  output logic [AddrWidth-1:0]              mem_addr_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  output logic [DataWidth/8-1:0]            mem_wstrb_o,
  input  logic                              mem_rsp_valid_i,
  output logic                              mem_rsp_ready_o,
  input  logic [DataWidth-1:0]              mem_rdata_i,
  input  logic                              mem_b_valid_i,
  output logic                              mem_b_ready_o,
  output logic [$clog2(MaxRdOutstanding):0] rd_outstanding_o,
  output logic [$clog2(MaxWrOutstanding):0] wr_outstanding_o,
  output logic                              err_o
);
  localparam int IdxW = $clog2(NumPorts);
  localparam int StrbW = DataWidth / 8;

  logic [IdxW-1:0]     r_rr;
  logic                r_lock;
  logic [IdxW-1:0]     r_lock_idx;
  logic                r_err;

  logic [NumPorts-1:0] w_elig;
  logic                w_any;
  logic [IdxW-1:0]     w_arb_idx;
  logic [IdxW-1:0]     w_grant;
  logic                w_hs;
  logic [IdxW-1:0]     w_rd_head, w_wr_head;
  logic                w_rd_empty, w_rd_full, w_wr_empty, w_wr_full;
  logic                w_rd_pop, w_wr_pop;

  always_comb begin
    w_elig    = '0;
    w_any     = 1'b0;
    w_arb_idx = '0;
    for (int p = 0; p < NumPorts; p++)
      w_elig[p] = req_valid_i[p] & (we_i[p] ? ~w_wr_full : ~w_rd_full);
    // Walk from the farthest offset back to the pointer so the nearest eligible port wins.
    for (int i = NumPorts - 1; i >= 0; i--) begin
      int s;
      s = int'(r_rr) + i;
      if (s >= NumPorts) s = s - NumPorts;
      if (w_elig[s]) begin
        w_arb_idx = s[IdxW-1:0];
        w_any     = 1'b1;
      end
    end
  end

  assign w_grant         = r_lock ? r_lock_idx : w_arb_idx;
  assign mem_req_valid_o = r_lock | w_any;
  assign w_hs            = mem_req_valid_o & mem_req_ready_i;
  assign mem_we_o        = we_i[w_grant];
  assign mem_addr_o      = addr_i[w_grant*AddrWidth +: AddrWidth];
  assign mem_wdata_o     = wdata_i[w_grant*DataWidth +: DataWidth];
  assign mem_wstrb_o     = wstrb_i[w_grant*StrbW +: StrbW];

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    b_valid_o   = '0;
    req_ready_o[w_grant]   = w_hs;
    rsp_valid_o[w_rd_head] = mem_rsp_valid_i & ~w_rd_empty;
    b_valid_o[w_wr_head]   = mem_b_valid_i & ~w_wr_empty;
  end

  // With an empty order FIFO the response has no owner: accept it so the model cannot stall.
  assign mem_rsp_ready_o = w_rd_empty ? 1'b1 : rsp_ready_i[w_rd_head];
  assign mem_b_ready_o   = w_wr_empty ? 1'b1 : b_ready_i[w_wr_head];
  assign w_rd_pop        = mem_rsp_valid_i & mem_rsp_ready_o & ~w_rd_empty;
  assign w_wr_pop        = mem_b_valid_i & mem_b_ready_o & ~w_wr_empty;
  assign rdata_o         = mem_rdata_i;
  assign err_o           = r_err;

  sim_dram_mux_ofifo #(.Depth(MaxRdOutstanding), .W(IdxW)) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs & ~mem_we_o),
    .data_i  (w_grant),
    .pop_i   (w_rd_pop),
    .head_o  (w_rd_head),
    .empty_o (w_rd_empty),
    .full_o  (w_rd_full),
    .count_o (rd_outstanding_o)
  );

  sim_dram_mux_ofifo #(.Depth(MaxWrOutstanding), .W(IdxW)) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs & mem_we_o),
    .data_i  (w_grant),
    .pop_i   (w_wr_pop),
    .head_o  (w_wr_head),
    .empty_o (w_wr_empty),
    .full_o  (w_wr_full),
    .count_o (wr_outstanding_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr   <= (w_grant == IdxW'(NumPorts - 1)) ? '0 : w_grant + 1'b1;
        r_lock <= 1'b0;
      end else if (mem_req_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      if ((mem_rsp_valid_i & w_rd_empty) | (mem_b_valid_i & w_wr_empty))
        r_err <= 1'b1;
    end
  end
endmodule
